// File: rtl/riscv_dmem_resp.sv
// Word-addressed data-memory responder: accepts one request at a time, inserts
// WAIT_CYC wait states, then completes with a single-cycle done pulse.
module riscv_dmem_resp #(
   parameter int XLEN          = 32,
   parameter int DMEM_ADDR_BIT = 12,
   parameter int WAIT_CYC      = 2
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_dmem_req,
   input  logic            i_dmem_wr_en,
   input  logic [XLEN-1:0] i_dmem_addr,
   input  logic [3:0]      i_dmem_byte_sel,
   input  logic [XLEN-1:0] i_dmem_wr_data,
   output logic            o_dmem_ready,
   output logic            o_dmem_done,
   output logic [XLEN-1:0] o_dmem_rd_data,
   output logic            o_dmem_err
);
   localparam int         IDX_W    = DMEM_ADDR_BIT - 2;
   localparam int         WORDS    = 1 << IDX_W;
   localparam logic [3:0] CNT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state_reg, state_next;
   logic [3:0]        cnt_reg, cnt_next;
   logic              wr_en_reg;
   logic [XLEN-1:0]   addr_reg;
   logic [3:0]        sel_reg;
   logic [XLEN-1:0]   wr_data_reg;
   logic [XLEN-1:0]   rd_data_reg;
   logic [XLEN-1:0]   mem [WORDS];

   logic              accept;
   logic              enter_resp;
   logic              mem_we;
   logic              src_wr_en;
   logic [XLEN-1:0]   src_addr;
   logic [3:0]        src_sel;
   logic [XLEN-1:0]   src_wr_data;
   logic [IDX_W-1:0]  src_idx;
   logic              src_err;
   logic [XLEN-1:0]   lane_mask;

   assign accept = (state_reg == IDLE) && i_dmem_req;

   // With WAIT_CYC=0 the array is accessed on the accept edge itself, so the
   // access fields come straight from the inputs while idle.
   assign src_wr_en   = (state_reg == IDLE) ? i_dmem_wr_en    : wr_en_reg;
   assign src_addr    = (state_reg == IDLE) ? i_dmem_addr     : addr_reg;
   assign src_sel     = (state_reg == IDLE) ? i_dmem_byte_sel : sel_reg;
   assign src_wr_data = (state_reg == IDLE) ? i_dmem_wr_data  : wr_data_reg;
   assign src_idx     = src_addr[DMEM_ADDR_BIT-1:2];
   assign src_err     = ((src_addr >> DMEM_ADDR_BIT) != '0) || (src_wr_en && (src_sel == 4'b0000));

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_mask[8*gi +: 8] = {8{src_sel[gi]}};
      end
      if (XLEN > 32) begin : g_upper
         assign lane_mask[XLEN-1:32] = '0;
      end
   endgenerate

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (i_dmem_req) begin
               if (WAIT_CYC == 0) begin
                  state_next = RESP;
               end else begin
                  state_next = WAIT;
                  cnt_next   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (cnt_reg == 4'd0) state_next = RESP;
            else                 cnt_next   = cnt_reg - 4'd1;
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         wr_en_reg   <= 1'b0;
         addr_reg    <= '0;
         sel_reg     <= 4'b0000;
         wr_data_reg <= '0;
      end else if (accept) begin
         wr_en_reg   <= i_dmem_wr_en;
         addr_reg    <= i_dmem_addr;
         sel_reg     <= i_dmem_byte_sel;
         wr_data_reg <= i_dmem_wr_data;
      end
   end

   assign enter_resp = (state_next == RESP) && (state_reg != RESP);
   assign mem_we     = enter_resp && src_wr_en && !src_err && i_rstn;

   always_ff @(posedge i_clk) begin
      if (mem_we)
         mem[src_idx] <= (mem[src_idx] & ~lane_mask) | (src_wr_data & lane_mask);
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)
         rd_data_reg <= '0;
      else if (enter_resp)
         rd_data_reg <= (!src_wr_en && !src_err) ? mem[src_idx] : '0;
      else if (state_reg == RESP)
         rd_data_reg <= '0;
   end

   assign o_dmem_ready   = (state_reg == IDLE);
   assign o_dmem_done    = (state_reg == RESP);
   assign o_dmem_err     = (state_reg == RESP) && src_err;
   assign o_dmem_rd_data = rd_data_reg;

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Bench for riscv_dmem_resp: a WAIT_CYC=2 instance driven from a vector table
// with a done-driven scoreboard, and a WAIT_CYC=0 instance under a held request.
module tb_riscv_dmem_resp;
   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rd;
   } vec_t;

   typedef struct packed {
      logic        err;
      logic [31:0] rd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_req, a_wr, a_ready, a_done, a_err;
   logic [31:0] a_addr, a_wdata, a_rd;
   logic [3:0]  a_sel;
   logic        b_req, b_wr, b_ready, b_done, b_err;
   logic [31:0] b_addr, b_wdata, b_rd;
   logic [3:0]  b_sel;

   int   check_cnt = 0;
   int   pass_cnt  = 0;
   exp_t exp_q[$];
   vec_t vecs[17];
   vec_t bvecs[4];

   always #5 clk = ~clk;

   riscv_dmem_resp #(.XLEN(32), .DMEM_ADDR_BIT(12), .WAIT_CYC(2)) u_dut_a (
      .i_clk(clk), .i_rstn(rst_n), .i_dmem_req(a_req), .i_dmem_wr_en(a_wr),
      .i_dmem_addr(a_addr), .i_dmem_byte_sel(a_sel), .i_dmem_wr_data(a_wdata),
      .o_dmem_ready(a_ready), .o_dmem_done(a_done), .o_dmem_rd_data(a_rd), .o_dmem_err(a_err)
   );

   riscv_dmem_resp #(.XLEN(32), .DMEM_ADDR_BIT(12), .WAIT_CYC(0)) u_dut_b (
      .i_clk(clk), .i_rstn(rst_n), .i_dmem_req(b_req), .i_dmem_wr_en(b_wr),
      .i_dmem_addr(b_addr), .i_dmem_byte_sel(b_sel), .i_dmem_wr_data(b_wdata),
      .o_dmem_ready(b_ready), .o_dmem_done(b_done), .o_dmem_rd_data(b_rd), .o_dmem_err(b_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Scoreboard: every done pulse from instance A retires the oldest expectation.
   always @(negedge clk) begin : sb_mon
      exp_t e;
      if (a_done === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("a_unexpected_done", {31'd0, a_done}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("a_err", {31'd0, a_err}, {31'd0, e.err});
            chk("a_rd_data", a_rd, e.rd);
         end
      end
   end

   task automatic run_a(input vec_t v);
      logic [3:0] rdy_p;
      logic [3:0] done_p;
      @(negedge clk);
      a_req = 1'b1; a_wr = v.wr; a_addr = v.addr; a_sel = v.sel; a_wdata = v.wdata;
      exp_q.push_back('{err: v.exp_err, rd: v.exp_rd});
      $display("txn A %s addr=0x%08h sel=%b wdata=0x%08h exp_err=%0b exp_rd=0x%08h",
               v.wr ? "WR" : "RD", v.addr, v.sel, v.wdata, v.exp_err, v.exp_rd);
      @(posedge clk); #1;
      // Scribble the request fields while busy; the captured copy must be used.
      a_req = 1'b0; a_wr = ~v.wr; a_addr = $urandom; a_sel = 4'($urandom); a_wdata = $urandom;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         rdy_p[k]  = a_ready;
         done_p[k] = a_done;
      end
      chk("a_ready_cycles1to4", {28'd0, rdy_p}, 32'h8);
      chk("a_done_cycles1to4", {28'd0, done_p}, 32'h4);
      chk("a_rd_cleared_after_resp", a_rd, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b1, 32'h0000_0000, 4'hF, 32'h1234_5678, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
      vecs[2]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         1'b0, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b1, 32'h0000_0010, 4'h2, 32'h0000_AA00, 1'b0, 32'h0};
      vecs[4]  = '{1'b0, 32'h0000_0013, 4'h0, 32'h0,         1'b0, 32'hDEAD_AAEF};
      vecs[5]  = '{1'b1, 32'h0000_1000, 4'hF, 32'h1111_1111, 1'b1, 32'h0};
      vecs[6]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         1'b0, 32'h1234_5678};
      vecs[7]  = '{1'b0, 32'h0000_1000, 4'h0, 32'h0,         1'b1, 32'h0};
      vecs[8]  = '{1'b1, 32'h0000_0014, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0};
      vecs[9]  = '{1'b1, 32'h0000_0014, 4'h0, 32'hFFFF_FFFF, 1'b1, 32'h0};
      vecs[10] = '{1'b0, 32'h0000_0014, 4'h0, 32'h0,         1'b0, 32'hCAFE_F00D};
      vecs[11] = '{1'b1, 32'h0000_0FFC, 4'hF, 32'h7654_3210, 1'b0, 32'h0};
      vecs[12] = '{1'b1, 32'h0000_0FFC, 4'h9, 32'hAB00_00CD, 1'b0, 32'h0};
      vecs[13] = '{1'b0, 32'h0000_0FFE, 4'h0, 32'h0,         1'b0, 32'hAB54_32CD};
      vecs[14] = '{1'b1, 32'h0000_1010, 4'hF, 32'h0,         1'b1, 32'h0};
      vecs[15] = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         1'b0, 32'hDEAD_AAEF};
      vecs[16] = '{1'b0, 32'h8000_0010, 4'h0, 32'h0,         1'b1, 32'h0};

      bvecs[0] = '{1'b1, 32'h0000_0040, 4'hF, 32'h0102_0304, 1'b0, 32'h0};
      bvecs[1] = '{1'b1, 32'h0000_0044, 4'hF, 32'hA5A5_A5A5, 1'b0, 32'h0};
      bvecs[2] = '{1'b0, 32'h0000_0040, 4'h0, 32'h0,         1'b0, 32'h0102_0304};
      bvecs[3] = '{1'b0, 32'h0000_0044, 4'h0, 32'h0,         1'b0, 32'hA5A5_A5A5};

      rst_n = 1'b0;
      a_req = 1'b0; a_wr = 1'b0; a_addr = '0; a_sel = '0; a_wdata = '0;
      b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_sel = '0; b_wdata = '0;
      #2;
      chk("reset_ready", {31'd0, a_ready}, 32'd1);
      chk("reset_done", {31'd0, a_done}, 32'd0);
      chk("reset_err", {31'd0, a_err}, 32'd0);
      chk("reset_rd_data", a_rd, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) run_a(vecs[i]);

      // Reset asserted mid-WAIT must abort the write with no done pulse.
      run_a('{1'b1, 32'h0000_0020, 4'hF, 32'hAAAA_5555, 1'b0, 32'h0});
      @(negedge clk);
      a_req = 1'b1; a_wr = 1'b1; a_addr = 32'h20; a_sel = 4'hF; a_wdata = 32'h9999_9999;
      $display("txn A WR addr=0x00000020 sel=1111 wdata=0x99999999 aborted by reset");
      @(posedge clk); #1;
      a_req = 1'b0;
      chk("abort_in_wait_ready", {31'd0, a_ready}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_ready", {31'd0, a_ready}, 32'd1);
      chk("async_reset_done", {31'd0, a_done}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_a('{1'b0, 32'h0000_0020, 4'h0, 32'h0, 1'b0, 32'hAAAA_5555});

      // WAIT_CYC=0 with request held high: accept on alternating edges.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         b_req = 1'b1; b_wr = bvecs[i].wr; b_addr = bvecs[i].addr;
         b_sel = bvecs[i].sel; b_wdata = bvecs[i].wdata;
         $display("txn B %s addr=0x%08h wdata=0x%08h exp_rd=0x%08h",
                  bvecs[i].wr ? "WR" : "RD", bvecs[i].addr, bvecs[i].wdata, bvecs[i].exp_rd);
         @(posedge clk); #1;
         chk("b_done_after_accept", {31'd0, b_done}, 32'd1);
         chk("b_ready_in_resp", {31'd0, b_ready}, 32'd0);
         chk("b_err", {31'd0, b_err}, 32'd0);
         chk("b_rd_data", b_rd, bvecs[i].exp_rd);
         b_wr = 1'b1; b_addr = 32'h40; b_sel = 4'hF; b_wdata = 32'hFFFF_FFFF;
         @(posedge clk); #1;
         chk("b_ready_idle", {31'd0, b_ready}, 32'd1);
         chk("b_done_idle", {31'd0, b_done}, 32'd0);
         chk("b_rd_cleared", b_rd, 32'h0);
      end
      @(negedge clk);
      b_req = 1'b0;
      repeat (2) @(negedge clk);

      chk("a_scoreboard_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end
endmodule
